// File: rtl/out_ctl_if.sv
// out_ctl_if: result stream bundle (valid/ready with data and last).
// master drives the stream, slave consumes it.
interface out_ctl_if #(
  parameter int DW = 32
);
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/out_ctl.sv
// out_ctl: copies a finished kernel into the shadow buffer and streams
// its result words out over valid/ready, counting kernels per stripe.
module out_ctl #(
  parameter  int WORDS = 8,
  parameter  int KN    = 4,
  parameter  int DW    = 32,
  localparam int AW    = $clog2(WORDS),
  localparam int CW    = AW + 1,
  localparam int KW    = (KN > 1) ? $clog2(KN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_init,
  input  logic          k_fin,
  output logic          cp,
  output logic          out_re,
  output logic [AW-1:0] out_a,
  input  logic [DW-1:0] rd_data,
  out_ctl_if.master     m,
  output logic          outr,
  output logic          out_busy,
  output logic          err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]    st_q, st_d;
  logic [CW-1:0] iss_q, iss_d;
  logic [CW-1:0] pop_q, pop_d;
  logic [KW-1:0] kc_q, kc_d;
  logic [1:0]    occ_q, occ_d;
  logic          rp_q, wp_q;
  logic          infl_q;
  logic          err_q, err_d;
  logic [DW-1:0] mem_q [2];

  logic          stream;
  logic          vld;
  logic [DW-1:0] head;
  logic          pop;
  logic          last_w;
  logic          fin_pop;
  logic          accept;
  logic          store;
  logic          drop;

  assign stream = (st_q == STREAM);

  // Fall-through FIFO: an arriving read word is visible at once
  // when nothing is stored, giving first data two cycles after cp.
  assign vld  = (occ_q != 2'd0) | infl_q;
  assign head = (occ_q != 2'd0) ? mem_q[rp_q] : rd_data;
  assign pop  = vld & m.m_ready;

  assign last_w  = (pop_q == CW'(WORDS - 1));
  assign fin_pop = stream & pop & last_w;
  assign accept  = k_fin & (~stream | fin_pop);

  assign store = infl_q & ~((occ_q == 2'd0) & pop);
  assign drop  = pop & (occ_q != 2'd0);

  assign cp     = rst & accept;
  assign out_re = stream
                & (iss_q < CW'(WORDS))
                & ((occ_q + {1'b0, infl_q}) < 2'd2);
  assign out_a  = iss_q[AW-1:0];

  assign m.m_valid = vld;
  assign m.m_data  = vld ? head : '0;
  assign m.m_last  = vld & last_w & (kc_q == KW'(KN - 1));

  assign outr     = stream;
  assign out_busy = stream;
  assign err      = err_q;

  always_comb begin
    st_d  = st_q;
    iss_d = iss_q;
    pop_d = pop_q;
    unique case (1'b1)
      accept: begin
        st_d  = STREAM;
        iss_d = '0;
        pop_d = '0;
      end
      fin_pop & ~k_fin: begin
        st_d  = IDLE;
        pop_d = pop_q + CW'(1);
      end
      default: begin
        iss_d = iss_q + CW'(out_re);
        pop_d = pop_q + CW'(pop);
      end
    endcase
  end

  always_comb begin
    kc_d = kc_q;
    if (s_init) begin
      kc_d = '0;
    end else if (fin_pop) begin
      kc_d = (kc_q == KW'(KN - 1)) ? '0 : kc_q + KW'(1);
    end
  end

  assign err_d = err_q | (k_fin & stream & ~fin_pop);
  assign occ_d = occ_q + {1'b0, store} - {1'b0, drop};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= IDLE;
      iss_q    <= '0;
      pop_q    <= '0;
      kc_q     <= '0;
      occ_q    <= '0;
      rp_q     <= 1'b0;
      wp_q     <= 1'b0;
      infl_q   <= 1'b0;
      err_q    <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      st_q   <= st_d;
      iss_q  <= iss_d;
      pop_q  <= pop_d;
      kc_q   <= kc_d;
      occ_q  <= occ_d;
      infl_q <= out_re;
      err_q  <= err_d;
      if (store) begin
        mem_q[wp_q] <= rd_data;
        wp_q        <= ~wp_q;
      end
      if (drop) begin
        rp_q <= ~rp_q;
      end
    end
  end

endmodule

// File: tb/tb_out_ctl.sv
// tb_out_ctl: random and directed stimulus against a word-queue model
// of the kernel result stream.
module tb_out_ctl;
  localparam int WORDS = 8;
  localparam int KN    = 4;
  localparam int DW    = 32;
  localparam int AW    = $clog2(WORDS);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_init = 1'b0;
  logic          k_fin = 1'b0;
  logic          cp, out_re, outr, out_busy, err;
  logic [AW-1:0] out_a;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] acc    [WORDS];
  logic [DW-1:0] shadow [WORDS];

  out_ctl_if #(.DW(DW)) m_if ();

  out_ctl #(.WORDS(WORDS), .KN(KN), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_init   (s_init),
    .k_fin    (k_fin),
    .cp       (cp),
    .out_re   (out_re),
    .out_a    (out_a),
    .rd_data  (rd_data),
    .m        (m_if),
    .outr     (outr),
    .out_busy (out_busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // external shadow buffer: captured on cp, synchronous read
  always @(posedge clk) begin
    if (cp) shadow <= acc;
    rd_data <= out_re ? shadow[out_a] : DW'($urandom);
  end

  logic [DW-1:0] expq[$];
  int            rem, out_cnt, iss_idx, since_cp, mk, pops_k;
  bit            merr, hold;
  logic [DW-1:0] hold_d;

  always @(negedge clk) begin : mon
    bit pop, exp_cp, lastw;
    if (!rst) begin
      chk("rst_cp", cp, 0);
      chk("rst_re", out_re, 0);
      chk("rst_a", out_a, 0);
      chk("rst_v", m_if.m_valid, 0);
      chk("rst_d", m_if.m_data, 0);
      chk("rst_l", m_if.m_last, 0);
      chk("rst_outr", outr, 0);
      chk("rst_busy", out_busy, 0);
      chk("rst_err", err, 0);
      expq.delete();
      rem = 0; out_cnt = 0; iss_idx = 0; since_cp = 100;
      mk = 0; pops_k = 0; merr = 0; hold = 0;
    end else begin
      if (since_cp < 100) since_cp++;
      pop    = m_if.m_valid && m_if.m_ready;
      lastw  = (rem == 1);
      exp_cp = k_fin && (rem == 0 || (lastw && pop));
      if (rem == 0) chk("idle_valid", m_if.m_valid, 0);
      chk("outr", outr, rem != 0);
      chk("busy", out_busy, rem != 0);
      chk("err", err, merr);
      chk("last", m_if.m_last, m_if.m_valid && lastw && mk == KN - 1);
      if (hold) begin
        chk("hold_v", m_if.m_valid, 1);
        chk("hold_d", m_if.m_data, hold_d);
      end
      if (since_cp == 1) begin
        chk("lat_re", out_re, 1);
        chk("lat_a", out_a, 0);
      end
      if (since_cp == 2) chk("lat_v", m_if.m_valid, 1);
      if (out_re) begin
        chk("re_lim", iss_idx < WORDS, 1);
        chk("re_a", out_a, iss_idx[AW-1:0]);
        iss_idx++;
      end
      if (pop && rem > 0) begin
        if (expq.size() == 0) chk("pop_empty", 1, 0);
        else chk("data", m_if.m_data, expq.pop_front());
        rem--;
        pops_k++;
      end
      out_cnt += int'(out_re) - int'(pop);
      chk("occ", out_cnt <= 2, 1);
      chk("cp", cp, exp_cp);
      if (s_init) mk = 0;
      else if (pop && lastw) mk = (mk + 1) % KN;
      if (exp_cp) begin
        foreach (acc[i]) expq.push_back(acc[i]);
        rem += WORDS;
        iss_idx = 0;
        since_cp = 0;
        pops_k = 0;
      end else if (k_fin) begin
        merr = 1;
      end
      hold   = m_if.m_valid && !m_if.m_ready;
      hold_d = m_if.m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kfin();
    foreach (acc[i]) acc[i] = $urandom;
    k_fin = 1'b1;
    tick();
    k_fin = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (outr && n < lim) begin
      tick();
      n++;
    end
    chk("idle_timeout", outr, 0);
  endtask

  initial begin
    int n;
    foreach (acc[i]) acc[i] = '0;
    m_if.m_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // single kernel, ready held high
    m_if.m_ready = 1'b1;
    s_init = 1'b1;
    tick();
    s_init = 1'b0;
    tick();
    kfin();
    n = 0;
    while (outr && n < 50) begin
      n++;
      tick();
    end
    chk("outr_len", n, WORDS + 1);

    // one full stripe
    s_init = 1'b1;
    tick();
    s_init = 1'b0;
    repeat (4) begin
      repeat ($urandom_range(0, 3)) tick();
      kfin();
      wait_idle(100);
    end

    // next kernel finishes on the final pop
    kfin();
    repeat (8) tick();
    foreach (acc[i]) acc[i] = $urandom;
    k_fin = 1'b1;
    #1;
    chk("b2b_cp", cp, 1);
    tick();
    k_fin = 1'b0;
    chk("b2b_outr", outr, 1);
    wait_idle(100);

    // random backpressure, kernel starts and stripe restarts
    repeat (400) begin
      m_if.m_ready = 1'($urandom % 2);
      s_init = ($urandom % 16 == 0);
      if (!outr && $urandom % 4 == 0) begin
        foreach (acc[i]) acc[i] = $urandom;
        k_fin = 1'b1;
      end else begin
        k_fin = 1'b0;
      end
      tick();
    end
    k_fin = 1'b0;
    s_init = 1'b0;
    m_if.m_ready = 1'b1;
    wait_idle(100);

    // protocol violation: second k_fin mid-stream
    kfin();
    tick();
    tick();
    k_fin = 1'b1;
    #1;
    chk("viol_cp", cp, 0);
    tick();
    k_fin = 1'b0;
    wait_idle(100);
    chk("err_set", err, 1);
    repeat (5) tick();
    chk("err_hold", err, 1);

    // reset mid-stream after three words
    kfin();
    n = 0;
    while (pops_k < 3 && n < 50) begin
      tick();
      n++;
    end
    chk("three_popped", pops_k, 3);
    rst = 1'b0;
    #1;
    chk("arst_v", m_if.m_valid, 0);
    chk("arst_outr", outr, 0);
    chk("arst_re", out_re, 0);
    chk("arst_err", err, 0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (6) tick();
    kfin();
    chk("restart_re", out_re, 1);
    chk("restart_a", out_a, 0);
    wait_idle(100);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
